// File: rtl/aes128_inv_cipher_iter_if.sv
// aes128_inv_cipher_iter_if: valid/ready block interface of the iterative AES-128 decryption core
// master drives ciphertext/key/out_ready; slave (the core) drives in_ready/busy/out_valid/plain_out
interface aes128_inv_cipher_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] cipher_in;
    logic [127:0] key_last_in;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plain_out;
    modport master (
        output in_valid, cipher_in, key_last_in, out_ready,
        input  in_ready, busy, out_valid, plain_out
    );
    modport slave (
        input  in_valid, cipher_in, key_last_in, out_ready,
        output in_ready, busy, out_valid, plain_out
    );
endinterface

// File: rtl/aes128_inv_cipher_iter.sv
// aes128_inv_cipher_iter: iterative AES-128 decryption, one inverse round per clock
// clk/rst_n: clock and async active-low reset
// bus.in_valid/in_ready/cipher_in/key_last_in: ciphertext + round-10 key accept handshake
// bus.busy: rounds executing; bus.out_valid/out_ready/plain_out: plaintext result handshake
module aes128_inv_cipher_iter #(
    parameter int ROUNDS = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    aes128_inv_cipher_iter_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (ROUNDS != 10) begin : g_bad_rounds
        $error("aes128_inv_cipher_iter: ROUNDS must be 10");
    end

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = xt(x);
        end
        return p;
    endfunction

    // multiplicative inverse as a^254; maps 0 to 0 as the S-box requires
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int i = 0; i < 7; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = ginv(b);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return ginv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        return r == 4'd9 ? 8'h1b : r == 4'd10 ? 8'h36 : 8'h01 << (r - 4'd1);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    logic [1:0]   fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [31:0]  w0, w1, w2, w3;
    logic [127:0] key_prev;
    logic [127:0] ark;
    logic [127:0] imc;

    // undo one key-schedule step: k_r -> k_{r-1}
    assign w3 = key_q[31:0] ^ key_q[63:32];
    assign w2 = key_q[63:32] ^ key_q[95:64];
    assign w1 = key_q[95:64] ^ key_q[127:96];
    assign w0 = key_q[127:96] ^ {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
              ^ {rcon(rnd_q), 24'h0};
    assign key_prev = {w0, w1, w2, w3};

    // InvShiftRows folded into the byte select: output (row, col) reads input (row, col-row)
    for (genvar i = 0; i < 16; i++) begin : g_byte
        localparam int src = 4 * (((i / 4) - (i % 4) + 4) % 4) + i % 4;
        assign ark[127-8*i -: 8] = inv_sbox(state_q[127-8*src -: 8]) ^ key_prev[127-8*i -: 8];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end

    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        key_d   = key_q;
        if (fsm_q == IDLE && bus.in_valid) begin
            fsm_d   = RUN;
            rnd_d   = 4'(ROUNDS);
            state_d = bus.cipher_in ^ bus.key_last_in;
            key_d   = bus.key_last_in;
        end else if (fsm_q == RUN) begin
            fsm_d   = rnd_q == 4'd1 ? DONE : RUN;
            rnd_d   = rnd_q - 4'd1;
            state_d = rnd_q == 4'd1 ? ark : imc;
            key_d   = key_prev;
        end else if (fsm_q == DONE && bus.out_ready) begin
            fsm_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            rnd_q   <= '0;
            state_q <= '0;
            key_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
            key_q   <= key_d;
        end
    end

    assign bus.in_ready  = fsm_q == IDLE;
    assign bus.busy      = fsm_q == RUN;
    assign bus.out_valid = fsm_q == DONE;
    // intermediate round states never leave the core
    assign bus.plain_out = fsm_q == DONE ? state_q : '0;
endmodule

// File: doc/aes128_inv_cipher_iter.md
Name: aes128_inv_cipher_iter

Overview:
- Iterative AES-128 decryption core, the inverse counterpart of the existing forward round datapath (one_round).
- Accepts a ciphertext and the final (round-10) round key. Runs the inverse key schedule on the fly and executes one inverse round per clock. Returns the plaintext over a valid/ready handshake.
- Sits beside the encryption path in the cipher test subsystem. Reuses the team's forward sbox module for the key schedule and a new inv_sbox module for InvSubBytes.

Parameters:
- ROUNDS, 10, number of rounds. Only 10 (AES-128) is legal. Any other value triggers a simulation $error at elaboration.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ciphertext/key presented.
- in_ready  output  1  core can accept a block.
- cipher_in  input  128  ciphertext, byte 0 in bits [127:120], FIPS-197 column-major order.
- key_last_in  input  128  round-10 round key, same byte order.
- busy  output  1  high while rounds are executing.
- out_valid  output  1  plain_out holds a result.
- out_ready  input  1  consumer accepts the result.
- plain_out  output  128  recovered plaintext.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - FSM goes to IDLE; round counter = 0.
  - state reg and key reg = 0.
  - in_ready=1, busy=0, out_valid=0, plain_out=0.
  - Reset asserted mid-operation aborts the block immediately. No partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On an edge with in_valid=1:
    - state <= cipher_in ^ key_last_in
    - key <= key_last_in
    - rnd <= 10
    - go to RUN.
  - RUN: in_ready=0, busy=1. Each edge:
    - key <= invexp(key, rnd)
    - state <= inv_round(state, invexp(key, rnd), final = (rnd==1))
    - rnd <= rnd-1
    - When rnd==1 on this edge, go to DONE.
  - DONE: out_valid=1, plain_out=state, both held stable. On an edge with out_ready=1, go to IDLE (out_valid drops next cycle).
- inv_round order:
  - InvShiftRows, then InvSubBytes, then AddRoundKey(k_{r-1}), then InvMixColumns.
  - InvMixColumns is omitted when final. Matrix {0e,0b,0d,09}, GF(2^8) reduction polynomial 0x11b.
- invexp(k_r, r): words w0..w3 of k_r, with w0 = bits [127:96].
  - w3' = w3^w2
  - w2' = w2^w1
  - w1' = w1^w0
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon[r],24'h0}
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Latency:
  - Accept edge T0.
  - out_valid first high after edge T0+10.
  - Minimum block-to-block spacing is 12 cycles with out_ready held at 1.
- Handshake boundaries:
  - in_valid while not IDLE is ignored. Inputs are sampled only on the accept edge.
  - Input changes during RUN have no effect.
  - out_ready while not DONE is ignored.
  - in_valid and out_ready both high in DONE: only the output handshake occurs. The input is accepted in IDLE on a later cycle.
- busy = (FSM==RUN). in_ready = (FSM==IDLE). Both are registered-state decodes; no combinational path from inputs.

Test Plan:
- FIPS-197 C.1: cipher 69c4e0d86a7b0430d8cdb78070b4c55a, key_last 13111d7fe3944a17f307a78b4d2b30c5 -> plain_out 00112233445566778899aabbccddeeff, out_valid exactly 10 cycles after accept.
- FIPS-197 App.B: cipher 3925841d02dc09fbdc118597196a0b32, key_last d014f9a8c9ee2589e13f0cc8b6630ca6 -> plaintext 3243f6a8885a308d313198a2e0370734.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> plain_out stable, in_ready=0 throughout. Raise out_ready -> out_valid low next cycle, in_ready high.
- Busy-input rejection: pulse in_valid with a different vector during RUN -> result is still the first vector's plaintext.
- Reset at cycle 5 of RUN -> all outputs read 0 immediately, in_ready=1. A subsequent C.1 vector decrypts correctly.
- Round-trip: feed 100 random (plaintext, key) pairs through one_round-based encryption plus a reference key expansion. Decrypting with the derived round-10 key -> every plaintext recovered.
